// File: rtl/adc_avg.sv
// Per-channel block averager: sums 2^N calibrated samples per channel and publishes the
// rounded mean into a CPU-readable bank with fresh/overrun flags.
module adc_avg #(
  parameter int unsigned ADC_NUM       = 16,
  parameter int unsigned ADC_NUM_WIDTH = $clog2(ADC_NUM + 1),
  parameter int unsigned AVG_MAX_LOG2  = 10,
  parameter int unsigned LOG2_WIDTH    = 4
) (
  input  logic                     aclr,
  input  logic                     clock,
  input  logic [31:0]              result,
  input  logic [ADC_NUM-1:0]       result_valid,
  input  logic [LOG2_WIDTH-1:0]    avg_log2,
  output logic [ADC_NUM*32-1:0]    avg,
  output logic [ADC_NUM-1:0]       avg_valid,
  input  logic                     rd_en,
  input  logic [ADC_NUM_WIDTH-1:0] rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_fresh,
  output logic                     rd_ovr,
  output logic                     multi_err
);

  localparam int unsigned AccW = 32 + AVG_MAX_LOG2;

  logic signed [AccW-1:0]   acc_q [ADC_NUM];
  logic signed [AccW-1:0]   acc_d [ADC_NUM];
  logic [AVG_MAX_LOG2-1:0]  cnt_q [ADC_NUM];
  logic [AVG_MAX_LOG2-1:0]  cnt_d [ADC_NUM];
  logic [31:0]              avg_q [ADC_NUM];
  logic [31:0]              avg_d [ADC_NUM];
  logic [ADC_NUM-1:0]       fresh_q, fresh_d, ovr_q, ovr_d, upd;
  logic [ADC_NUM-1:0]       avg_valid_q;
  logic [LOG2_WIDTH-1:0]    n_q, n_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic                     rd_fresh_q, rd_fresh_d, rd_ovr_q, rd_ovr_d;
  logic                     multi_err_q, multi_err_d;

  logic                     restart;
  logic [AVG_MAX_LOG2:0]    blk;
  logic [AVG_MAX_LOG2-1:0]  cnt_last;
  logic signed [AccW-1:0]   rnd, sample_ext, sum, mean;

  always_comb begin
    n_d = (int'(avg_log2) > int'(AVG_MAX_LOG2)) ? LOG2_WIDTH'(AVG_MAX_LOG2) : avg_log2;
    restart = (n_d != n_q);
    blk = (AVG_MAX_LOG2 + 1)'(1) << n_q;
    cnt_last = AVG_MAX_LOG2'(blk - (AVG_MAX_LOG2 + 1)'(1));
    // Half an LSB of the mean; zero when N == 0 so the shift path also covers that case.
    rnd = AccW'(blk >> 1);
    sample_ext = {{AVG_MAX_LOG2{result[31]}}, result};
    multi_err_d = multi_err_q | ((result_valid & (result_valid - ADC_NUM'(1))) != '0);

    rd_data_d  = rd_data_q;
    rd_fresh_d = rd_fresh_q;
    rd_ovr_d   = rd_ovr_q;
    if (rd_en) begin
      rd_data_d  = '0;
      rd_fresh_d = 1'b0;
      rd_ovr_d   = 1'b0;
    end

    fresh_d = fresh_q;
    ovr_d   = ovr_q;
    upd     = '0;
    sum     = '0;
    mean    = '0;
    for (int i = 0; i < int'(ADC_NUM); i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = cnt_q[i];
      avg_d[i] = avg_q[i];
      sum  = acc_q[i] + sample_ext;
      mean = (sum + rnd) >>> n_q;
      if (restart) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end else if (result_valid[i]) begin
        if (cnt_q[i] == cnt_last) begin
          avg_d[i] = mean[31:0];
          acc_d[i] = '0;
          cnt_d[i] = '0;
          upd[i]   = 1'b1;
        end else begin
          acc_d[i] = sum;
          cnt_d[i] = cnt_q[i] + AVG_MAX_LOG2'(1);
        end
      end

      if (rd_en && (rd_addr == ADC_NUM_WIDTH'(i))) begin
        rd_data_d  = avg_q[i];
        rd_fresh_d = fresh_q[i];
        rd_ovr_d   = ovr_q[i];
        fresh_d[i] = 1'b0;
        ovr_d[i]   = 1'b0;
      end
      // An update in the same cycle as a read keeps the channel marked unread.
      if (upd[i]) begin
        ovr_d[i]   = ovr_q[i] | fresh_q[i];
        fresh_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < int'(ADC_NUM); i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        avg_q[i] <= '0;
      end
      fresh_q     <= '0;
      ovr_q       <= '0;
      avg_valid_q <= '0;
      n_q         <= '0;
      rd_data_q   <= '0;
      rd_fresh_q  <= 1'b0;
      rd_ovr_q    <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(ADC_NUM); i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
        avg_q[i] <= avg_d[i];
      end
      fresh_q     <= fresh_d;
      ovr_q       <= ovr_d;
      avg_valid_q <= upd;
      n_q         <= n_d;
      rd_data_q   <= rd_data_d;
      rd_fresh_q  <= rd_fresh_d;
      rd_ovr_q    <= rd_ovr_d;
      multi_err_q <= multi_err_d;
    end
  end

  always_comb begin
    avg = '0;
    for (int i = 0; i < int'(ADC_NUM); i++) begin
      avg[i*32 +: 32] = avg_q[i];
    end
  end

  assign avg_valid = avg_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_fresh  = rd_fresh_q;
  assign rd_ovr    = rd_ovr_q;
  assign multi_err = multi_err_q;

endmodule
